// File: rtl/window_line_buffer.sv
// Streaming KSIZE x KSIZE window generator over a raster pixel stream.
// Keeps KSIZE-1 previous lines on chip. Extra padding cycles at each row end
// and at frame end let edge pixels receive full windows. Out-of-image taps are
// zeroed or replicated, based only on the window centre coordinates.
module window_line_buffer #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned IMG_W  = 640,
    parameter int unsigned IMG_H  = 480,
    parameter int unsigned KSIZE  = 3,
    parameter int unsigned BORDER = 0
) (
    input  logic                          pclk,
    input  logic                          rst_n,
    input  logic                          in_sof,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          out_valid,
    output logic                          out_sof,
    output logic [$clog2(IMG_W)-1:0]      out_x,
    output logic [$clog2(IMG_H)-1:0]      out_y,
    output logic [KSIZE*KSIZE*DATA_W-1:0] out_window
);

    localparam int unsigned R     = (KSIZE - 1) / 2;
    localparam int unsigned XW    = $clog2(IMG_W);
    localparam int unsigned YW    = $clog2(IMG_H);
    localparam int unsigned VXW   = $clog2(IMG_W + R);
    localparam int unsigned VYW   = $clog2(IMG_H + R);
    localparam int unsigned IDXW  = $clog2(KSIZE);
    localparam int unsigned WIN_W = KSIZE * KSIZE * DATA_W;

    localparam int KI    = int'(KSIZE);
    localparam int NLI   = int'(KSIZE) - 1;
    localparam int RI    = int'(R);
    localparam int IMG_WI = int'(IMG_W);
    localparam int IMG_HI = int'(IMG_H);

    localparam logic [VXW-1:0] LAST_X  = VXW'(IMG_W + R - 1);
    localparam logic [VYW-1:0] LAST_Y  = VYW'(IMG_H + R - 1);
    localparam logic [VXW-1:0] IMG_W_V = VXW'(IMG_W);
    localparam logic [VYW-1:0] IMG_H_V = VYW'(IMG_H);
    localparam logic [VXW-1:0] R_X     = VXW'(R);
    localparam logic [VYW-1:0] R_Y     = VYW'(R);

    typedef enum logic {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [VXW-1:0]   vx_q, vx_d;
    logic [VYW-1:0]   vy_q, vy_d;

    logic             out_valid_q, out_valid_d;
    logic             out_sof_q, out_sof_d;
    logic [XW-1:0]    out_x_q, out_x_d;
    logic [YW-1:0]    out_y_q, out_y_d;
    logic [WIN_W-1:0] out_window_q, win_o;

    // Position handled by this cycle's advance (sof restarts at (0,0))
    logic             adv;
    logic [VXW-1:0]   px, cx_v;
    logic [VYW-1:0]   py, cy_v;
    logic             real_pos;

    logic             in_col, in_row;
    logic [XW-1:0]    col_idx;
    logic [DATA_W-1:0] cur_pix;
    logic [DATA_W-1:0] col [KSIZE];

    // line_mem[0] holds the previous line, line_mem[k] the line k+1 rows up
    logic [DATA_W-1:0] line_mem [KSIZE-1][IMG_W];
    logic [DATA_W-1:0] win_q [KSIZE][KSIZE];
    logic [DATA_W-1:0] win_d [KSIZE][KSIZE];

    // Scan control: decide whether and where the virtual scan advances
    always_comb begin
        state_d  = state_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        adv      = 1'b0;
        px       = vx_q;
        py       = vy_q;
        in_ready = 1'b1;
        real_pos = (vx_q < IMG_W_V) && (vy_q < IMG_H_V);
        unique case (state_q)
            StIdle: begin
                if (in_valid && in_sof) begin
                    adv = 1'b1;
                    px  = '0;
                    py  = '0;
                end
            end
            StRun: begin
                if (real_pos) begin
                    if (in_valid) begin
                        adv = 1'b1;
                        // sof mid-frame aborts and restarts at (0,0)
                        if (in_sof) begin
                            px = '0;
                            py = '0;
                        end
                    end
                end else begin
                    in_ready = 1'b0;
                    adv      = 1'b1;
                end
            end
            default: ;
        endcase
        if (adv) begin
            if (px == LAST_X) begin
                vx_d = '0;
                if (py == LAST_Y) begin
                    vy_d    = '0;
                    state_d = StIdle;
                end else begin
                    vy_d    = py + 1'b1;
                    state_d = StRun;
                end
            end else begin
                vx_d    = px + 1'b1;
                vy_d    = py;
                state_d = StRun;
            end
        end
    end

    // Build the incoming column: stored lines above, current pixel at the bottom
    always_comb begin
        in_col  = px < IMG_W_V;
        in_row  = py < IMG_H_V;
        col_idx = px[XW-1:0];
        cur_pix = (in_col && in_row) ? in_data : '0;
        for (int r = 0; r < NLI; r++) begin
            col[r] = in_col ? line_mem[NLI-1-r][col_idx] : '0;
        end
        col[KSIZE-1] = cur_pix;
    end

    // Line memory chain: push current pixel down one line at this column
    always_ff @(posedge pclk) begin
        if (adv && in_col) begin
            line_mem[0][col_idx] <= cur_pix;
            for (int k = 1; k < NLI; k++) begin
                line_mem[k][col_idx] <= line_mem[k-1][col_idx];
            end
        end
    end

    // Window shift: oldest column leaves on the left, new column enters right
    always_comb begin
        win_d = win_q;
        if (adv) begin
            for (int r = 0; r < KI; r++) begin
                for (int c = 0; c < KI; c++) begin
                    if (c < KI - 1) win_d[r][c] = win_q[r][c+1];
                    else            win_d[r][c] = col[r];
                end
            end
        end
    end

    // Window register; contents outside the image are masked downstream
    always_ff @(posedge pclk) begin
        win_q <= win_d;
    end

    // Border handling from the centre coordinates only
    always_comb begin
        int cxi, cyi, sy, sx;
        logic [IDXW-1:0] rr, cc;
        win_o       = '0;
        cx_v        = px - R_X;
        cy_v        = py - R_Y;
        cxi         = int'(px) - RI;
        cyi         = int'(py) - RI;
        sy          = 0;
        sx          = 0;
        rr          = '0;
        cc          = '0;
        out_valid_d = adv && (px >= R_X) && (py >= R_Y);
        out_sof_d   = out_valid_d && (px == R_X) && (py == R_Y);
        out_x_d     = cx_v[XW-1:0];
        out_y_d     = cy_v[YW-1:0];
        for (int r = 0; r < KI; r++) begin
            for (int c = 0; c < KI; c++) begin
                sy = cyi + r - RI;
                sx = cxi + c - RI;
                if (BORDER == 0) begin
                    if (sy >= 0 && sy < IMG_HI && sx >= 0 && sx < IMG_WI) begin
                        win_o[(r*KI+c)*DATA_W +: DATA_W] = win_d[r][c];
                    end
                end else begin
                    if (sy < 0) sy = 0;
                    if (sy > IMG_HI - 1) sy = IMG_HI - 1;
                    if (sx < 0) sx = 0;
                    if (sx > IMG_WI - 1) sx = IMG_WI - 1;
                    rr = IDXW'(sy - cyi + RI);
                    cc = IDXW'(sx - cxi + RI);
                    win_o[(r*KI+c)*DATA_W +: DATA_W] = win_d[rr][cc];
                end
            end
        end
    end

    // FSM state, scan counters and registered outputs
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            vx_q         <= '0;
            vy_q         <= '0;
            out_valid_q  <= 1'b0;
            out_sof_q    <= 1'b0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_window_q <= '0;
        end else begin
            state_q     <= state_d;
            vx_q        <= vx_d;
            vy_q        <= vy_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            if (out_valid_d) begin
                out_x_q      <= out_x_d;
                out_y_q      <= out_y_d;
                out_window_q <= win_o;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sof    = out_sof_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_window = out_window_q;

endmodule

// File: tb/tb_window_line_buffer.sv
// Bench for window_line_buffer on an 8x6 image: two 3x3 instances (zero and
// replicate borders) sharing one input stream, plus a 5x5 zero-border instance.
module tb_window_line_buffer;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n;

    logic         a_sof, a_valid, b_sof, b_valid;
    logic [7:0]   a_data, b_data;
    logic         ra, r1, rb;
    logic         o0_valid, o0_sof, o1_valid, o1_sof, o2_valid, o2_sof;
    logic [2:0]   o0_x, o0_y, o1_x, o1_y, o2_x, o2_y;
    logic [71:0]  o0_win, o1_win;
    logic [199:0] o2_win;

    always #5 clk = ~clk;

    window_line_buffer #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .KSIZE(3), .BORDER(0)) d0 (
        .pclk(clk), .rst_n(rst_n), .in_sof(a_sof), .in_valid(a_valid), .in_ready(ra),
        .in_data(a_data), .out_valid(o0_valid), .out_sof(o0_sof), .out_x(o0_x),
        .out_y(o0_y), .out_window(o0_win));

    window_line_buffer #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .KSIZE(3), .BORDER(1)) d1 (
        .pclk(clk), .rst_n(rst_n), .in_sof(a_sof), .in_valid(a_valid), .in_ready(r1),
        .in_data(a_data), .out_valid(o1_valid), .out_sof(o1_sof), .out_x(o1_x),
        .out_y(o1_y), .out_window(o1_win));

    window_line_buffer #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .KSIZE(5), .BORDER(0)) d2 (
        .pclk(clk), .rst_n(rst_n), .in_sof(b_sof), .in_valid(b_valid), .in_ready(rb),
        .in_data(b_data), .out_valid(o2_valid), .out_sof(o2_sof), .out_x(o2_x),
        .out_y(o2_y), .out_window(o2_win));

    typedef struct packed {
        logic         sof;
        logic [2:0]   x;
        logic [2:0]   y;
        logic [199:0] w;
    } obs_t;

    obs_t q0[$], q1[$], q2[$], saved0[$], saved1[$];
    int   checks = 0;
    int   errors = 0;
    int   img [2][H][W];
    int   low_a = 0, run_a = 0, last_run_a = 0, runs_a = 0;
    int   low_b = 0, run_b = 0, last_run_b = 0, runs_b = 0;

    // Collect every presented window
    always @(negedge clk) begin
        if (o0_valid) q0.push_back(obs_t'{sof: o0_sof, x: o0_x, y: o0_y, w: 200'(o0_win)});
        if (o1_valid) q1.push_back(obs_t'{sof: o1_sof, x: o1_x, y: o1_y, w: 200'(o1_win)});
        if (o2_valid) q2.push_back(obs_t'{sof: o2_sof, x: o2_x, y: o2_y, w: o2_win});
    end

    // Track in_ready low cycles and lengths of low runs
    always @(negedge clk) begin
        if (!ra) begin
            low_a++;
            run_a++;
        end else begin
            if (run_a > 0) begin
                last_run_a = run_a;
                runs_a++;
            end
            run_a = 0;
        end
        if (!rb) begin
            low_b++;
            run_b++;
        end else begin
            if (run_b > 0) begin
                last_run_b = run_b;
                runs_b++;
            end
            run_b = 0;
        end
    end

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference window straight from the image and the border rule
    function automatic logic [199:0] exp_win(input int src, input int k, input int b,
                                             input int cx, input int cy);
        logic [199:0] w;
        int r, sy, sx, v;
        w = '0;
        r = (k - 1) / 2;
        for (int tr = 0; tr < k; tr++) begin
            for (int tc = 0; tc < k; tc++) begin
                sy = cy + tr - r;
                sx = cx + tc - r;
                v  = 0;
                if (b == 1) begin
                    sy = (sy < 0) ? 0 : ((sy > H - 1) ? H - 1 : sy);
                    sx = (sx < 0) ? 0 : ((sx > W - 1) ? W - 1 : sx);
                    v  = img[src][sy][sx];
                end else if (sy >= 0 && sy < H && sx >= 0 && sx < W) begin
                    v = img[src][sy][sx];
                end
                w[(tr*k+tc)*DW +: DW] = 8'(v);
            end
        end
        return w;
    endfunction

    function automatic logic [199:0] pack9(input int v [9]);
        logic [199:0] w;
        w = '0;
        for (int i = 0; i < 9; i++) w[i*DW +: DW] = 8'(v[i]);
        return w;
    endfunction

    function automatic int qsize(input int inst);
        if (inst == 0) return q0.size();
        if (inst == 1) return q1.size();
        return q2.size();
    endfunction

    function automatic obs_t qget(input int inst, input int i);
        if (inst == 0) return q0[i];
        if (inst == 1) return q1[i];
        return q2[i];
    endfunction

    task automatic clear_all();
        q0.delete();
        q1.delete();
        q2.delete();
        low_a = 0; last_run_a = 0; runs_a = 0;
        low_b = 0; last_run_b = 0; runs_b = 0;
    endtask

    task automatic drive(input int g, input logic v, input logic s, input int d);
        if (g == 0) begin
            a_valid = v; a_sof = s; a_data = 8'(d);
        end else begin
            b_valid = v; b_sof = s; b_data = 8'(d);
        end
    endtask

    // Present one pixel (after optional random idle cycles) until accepted
    task automatic send_px(input int g, input int d, input logic s, input int gap);
        logic rdy;
        int   budget;
        while (gap > 0 && $urandom_range(99) < gap) begin
            drive(g, 1'b0, 1'b0, 0);
            @(negedge clk);
        end
        drive(g, 1'b1, s, d);
        budget = 0;
        while (1) begin
            rdy = (g == 0) ? ra : rb;
            @(negedge clk);
            if (rdy) break;
            budget++;
            if (budget > 100) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", budget);
                break;
            end
        end
        drive(g, 1'b0, 1'b0, 0);
    endtask

    task automatic send_img(input int g, input int src, input int gap, input int n,
                            input logic first_sof);
        for (int i = 0; i < n; i++) begin
            send_px(g, img[src][i/W][i%W], first_sof && (i == 0), gap);
        end
    endtask

    // Expected: old-frame windows triggered before the abort point, then a full new frame
    task automatic check_frame(input int inst, input int k, input int b, input int old_src,
                               input int limit, input int new_src);
        obs_t exp_q[$];
        obs_t got;
        int   r, n;
        r = (k - 1) / 2;
        if (limit >= 0) begin
            for (int cy = 0; cy < H; cy++)
                for (int cx = 0; cx < W; cx++)
                    if ((cy + r) * (W + r) + cx + r < limit)
                        exp_q.push_back(obs_t'{sof: (cx == 0 && cy == 0), x: 3'(cx), y: 3'(cy),
                                               w: exp_win(old_src, k, b, cx, cy)});
        end
        for (int cy = 0; cy < H; cy++)
            for (int cx = 0; cx < W; cx++)
                exp_q.push_back(obs_t'{sof: (cx == 0 && cy == 0), x: 3'(cx), y: 3'(cy),
                                       w: exp_win(new_src, k, b, cx, cy)});
        n = qsize(inst);
        check($sformatf("inst%0d window_count", inst), 200'(n), 200'(exp_q.size()));
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            got = qget(inst, i);
            check($sformatf("inst%0d centre#%0d", inst, i), 200'({got.sof, got.x, got.y}),
                  200'({exp_q[i].sof, exp_q[i].x, exp_q[i].y}));
            check($sformatf("inst%0d window#%0d", inst, i), got.w, exp_q[i].w);
        end
    endtask

    initial begin
        int           v9 [9];
        int           nsof, old_hi, limit;
        logic [199:0] w, mask;

        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 0);
        drive(1, 1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);

        // Reset state
        check("rst out_valid", 200'(o0_valid), 200'(0));
        check("rst out_sof", 200'(o0_sof), 200'(0));
        check("rst out_xy", 200'({o0_x, o0_y}), 200'(0));
        check("rst out_window", 200'(o0_win), 200'(0));
        check("rst in_ready", 200'(ra), 200'(1));
        check("rst k5 window", o2_win, 200'(0));
        check("rst k5 in_ready", 200'(rb), 200'(1));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle out_valid", 200'({o0_valid, o1_valid, o2_valid}), 200'(0));

        // Gap-free frame, data 8y+x
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[0][y][x] = 8 * y + x;
        clear_all();
        send_img(0, 0, 0, W * H, 1'b1);
        repeat (40) @(negedge clk);
        check("b0 count", 200'(q0.size()), 200'(48));
        if (q0.size() == 48) begin
            v9 = '{0, 0, 0, 0, 0, 1, 0, 8, 9};
            check("b0 c00", q0[0].w, pack9(v9));
            v9 = '{38, 39, 0, 46, 47, 0, 0, 0, 0};
            check("b0 c75", q0[47].w, pack9(v9));
        end
        if (q1.size() == 48) begin
            v9 = '{0, 0, 1, 0, 0, 1, 8, 8, 9};
            check("b1 c00", q1[0].w, pack9(v9));
            v9 = '{38, 39, 39, 46, 47, 47, 46, 47, 47};
            check("b1 c75", q1[47].w, pack9(v9));
        end
        nsof = 0;
        foreach (q0[i]) if (q0[i].sof) nsof++;
        check("b0 sof_count", 200'(nsof), 200'(1));
        check_frame(0, 3, 0, 0, -1, 0);
        check_frame(1, 3, 1, 0, -1, 0);
        // One padding slot per row end; last row end runs into the padding row
        check("ready low total", 200'(low_a), 200'(15));
        check("ready last run", 200'(last_run_a), 200'(10));
        check("ready low runs", 200'(runs_a), 200'(6));
        saved0 = q0;
        saved1 = q1;

        // Same frame with random input gaps
        clear_all();
        send_img(0, 0, 50, W * H, 1'b1);
        repeat (40) @(negedge clk);
        check("gap count", 200'(q0.size()), 200'(saved0.size()));
        for (int i = 0; i < q0.size() && i < saved0.size(); i++)
            check($sformatf("gap vs nogap b0 #%0d", i), q0[i], saved0[i]);
        for (int i = 0; i < q1.size() && i < saved1.size(); i++)
            check($sformatf("gap vs nogap b1 #%0d", i), q1[i], saved1[i]);
        check("gap ready low total", 200'(low_a), 200'(15));
        check("gap ready last run", 200'(last_run_a), 200'(10));

        // Random pixel data with gaps
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[0][y][x] = $urandom_range(255);
        clear_all();
        send_img(0, 0, 30, W * H, 1'b1);
        repeat (40) @(negedge clk);
        check_frame(0, 3, 0, 0, -1, 0);
        check_frame(1, 3, 1, 0, -1, 0);

        // 5x5 window, data 8y+x
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[0][y][x] = 8 * y + x;
        clear_all();
        send_img(1, 0, 0, W * H, 1'b1);
        repeat (40) @(negedge clk);
        check_frame(2, 5, 0, 0, -1, 0);
        if (q2.size() == 48) begin
            w = '0;
            for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) w[(r*5+c)*DW +: DW] = 8'(8 * r + c);
            check("k5 c22", q2[18].w, w);
            mask = '0;
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    if (r < 2 || c < 2) mask[(r*5+c)*DW +: DW] = 8'hff;
            check("k5 c00 border taps", q2[0].w & mask, 200'(0));
        end
        check("k5 ready low total", 200'(low_b), 200'(32));
        check("k5 ready last run", 200'(last_run_b), 200'(22));

        // Abort: sof on the 20th pixel starts a fresh frame
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                img[0][y][x] = $urandom_range(255);
                img[1][y][x] = $urandom_range(255);
            end
        clear_all();
        send_img(0, 0, 0, 19, 1'b1);
        send_img(0, 1, 0, W * H, 1'b1);
        repeat (40) @(negedge clk);
        limit = (19 / W) * (W + 1) + 19 % W;
        check_frame(0, 3, 0, 0, limit, 1);
        check_frame(1, 3, 1, 0, limit, 1);

        clear_all();
        send_img(1, 0, 0, 19, 1'b1);
        send_img(1, 1, 0, W * H, 1'b1);
        repeat (40) @(negedge clk);
        limit = (19 / W) * (W + 2) + 19 % W;
        check_frame(2, 5, 0, 0, limit, 1);
        old_hi = 0;
        for (int i = 0; i < q2.size(); i++) begin
            if (q2[i].sof && i > 0) break;
            if (q2[i].y >= 1) old_hi++;
        end
        check("k5 abort old rows>=1", 200'(old_hi), 200'(0));

        // Reset in the middle of a frame
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[0][y][x] = $urandom_range(255);
        clear_all();
        send_img(0, 0, 0, 30, 1'b1);
        check("pre-reset out_valid", 200'(o0_valid), 200'(1));
        rst_n = 1'b0;
        #1;
        check("reset out_valid now", 200'({o0_valid, o1_valid}), 200'(0));
        repeat (2) @(negedge clk);
        check("reset out_valid held", 200'({o0_valid, o1_valid}), 200'(0));
        rst_n = 1'b1;
        q0.delete();
        q1.delete();
        send_img(0, 0, 0, 12, 1'b0);
        repeat (20) @(negedge clk);
        check("no sof no output b0", 200'(q0.size()), 200'(0));
        check("no sof no output b1", 200'(q1.size()), 200'(0));
        send_img(0, 1, 0, W * H, 1'b1);
        repeat (40) @(negedge clk);
        check_frame(0, 3, 0, 1, -1, 1);
        check_frame(1, 3, 1, 1, -1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
